loadstore: RTL

LOADSTORE -- requirements
Module: loadstore

---
 rtl/loadstore.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/loadstore.sv
// Load/store stage: passes ALU results through to write-back or runs one
// pipelined Wishbone transfer with byte-lane alignment and load extension.
module loadstore (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] result_i,
  input  logic        enable_i,
  input  logic        write_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] write_data_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;
  localparam logic [2:0] FUNC3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Unknown func3 codes fall back to a full-word access.
  function automatic size_e access_size(input logic we, input logic [2:0] f3);
    size_e sz;
    sz = SZ_WORD;
    if (we) begin
      case (f3)
        FUNC3_SB: sz = SZ_BYTE;
        FUNC3_SH: sz = SZ_HALF;
        FUNC3_SW: sz = SZ_WORD;
        default:  sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        FUNC3_LB, FUNC3_LBU: sz = SZ_BYTE;
        FUNC3_LH, FUNC3_LHU: sz = SZ_HALF;
        FUNC3_LW:            sz = SZ_WORD;
        default:             sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic [4:0] lane_shift(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return {off, 3'b000};
      SZ_HALF: return {off[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [31:0] lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    lane   = raw >> lane_shift(access_size(1'b0, f3), off);
    lane_b = lane[7:0];
    lane_h = lane[15:0];
    case (f3)
      FUNC3_LB:  return 32'(lane_b);
      FUNC3_LH:  return 32'(lane_h);
      FUNC3_LBU: return {24'd0, lane[7:0]};
      FUNC3_LHU: return {16'd0, lane[15:0]};
      default:   return lane;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        accept, done;
  size_e       req_size;

  logic [31:0] adr_p1, dat_p1;
  logic [3:0]  sel_p1;
  logic        we_p1, rd_write_p1;
  logic [1:0]  off_p1;
  logic [2:0]  func3_p1;
  logic [4:0]  rd_addr_p1;

  logic        vld_p2, rd_write_p2;
  logic [4:0]  rd_addr_p2;
  logic [31:0] rd_data_p2;

  assign req_size = access_size(write_i, func3_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    input_ready_o = 1'b0;
    wb_cyc_o      = 1'b0;
    wb_stb_o      = 1'b0;
    accept        = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        input_ready_o = 1'b1;
        accept        = input_valid_i;
        if (input_valid_i && enable_i) state_d = REQUEST;
      end
      REQUEST: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        if (!wb_stall_i) begin
          done    = wb_ack_i;
          state_d = wb_ack_i ? IDLE : WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        wb_cyc_o = 1'b1;
        done     = wb_ack_i;
        if (wb_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p1: request captured on accept; p2: write-back result, one-cycle valid pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_p1      <= '0;
      dat_p1      <= '0;
      sel_p1      <= '0;
      we_p1       <= 1'b0;
      off_p1      <= '0;
      func3_p1    <= '0;
      rd_write_p1 <= 1'b0;
      rd_addr_p1  <= '0;
      vld_p2      <= 1'b0;
      rd_write_p2 <= 1'b0;
      rd_addr_p2  <= '0;
      rd_data_p2  <= '0;
    end else begin
      vld_p2      <= 1'b0;
      rd_write_p2 <= 1'b0;
      if (accept && enable_i) begin
        adr_p1      <= {result_i[31:2], 2'b00};
        dat_p1      <= write_data_i << lane_shift(req_size, result_i[1:0]);
        sel_p1      <= lane_sel(req_size, result_i[1:0]);
        we_p1       <= write_i;
        off_p1      <= result_i[1:0];
        func3_p1    <= func3_i;
        rd_write_p1 <= reg_write_i;
        rd_addr_p1  <= reg_addr_i;
      end else if (accept) begin
        vld_p2      <= 1'b1;
        rd_write_p2 <= reg_write_i;
        rd_addr_p2  <= reg_addr_i;
        rd_data_p2  <= result_i;
      end
      if (done) begin
        vld_p2      <= 1'b1;
        rd_write_p2 <= rd_write_p1 & ~we_p1;
        rd_addr_p2  <= rd_addr_p1;
        rd_data_p2  <= we_p1 ? 32'd0 : load_extract(wb_dat_i, func3_p1, off_p1);
      end
    end
  end

  assign wb_adr_o       = adr_p1;
  assign wb_dat_o       = dat_p1;
  assign wb_sel_o       = wb_cyc_o ? sel_p1 : 4'b0000;
  assign wb_we_o        = wb_cyc_o & we_p1;
  assign output_valid_o = vld_p2;
  assign reg_write_o    = rd_write_p2;
  assign reg_addr_o     = rd_addr_p2;
  assign reg_data_o     = rd_data_p2;

endmodule
